// File: rtl/ccpd_hit_gate_counter.sv
// CCPD hit-gate counter: counts synchronised MONHIT rising edges inside each CCPD_GATE window
// and queues one 32-bit summary word per window in a first-word-fall-through FIFO.
module ccpd_hit_gate_counter #(
   parameter logic [3:0] DATA_IDENTIFIER = 4'b0111,
   parameter int         FIFO_DEPTH      = 16
) (
   input  logic        BUS_CLK,
   input  logic        BUS_RST_B,
   input  logic        ENABLE,
   input  logic        GATE_IN,
   input  logic        HIT_IN,
   input  logic        CLEAR,
   input  logic        FIFO_READ,
   output logic        FIFO_EMPTY,
   output logic [31:0] FIFO_DATA,
   output logic [7:0]  LOST_CNT,
   output logic        BUSY
);

   localparam int             AW      = $clog2(FIFO_DEPTH);
   localparam logic [AW:0]    DEPTH_C = (AW+1)'(FIFO_DEPTH);
   localparam logic [AW:0]    CNT_ONE = (AW+1)'(1);
   localparam logic [AW-1:0]  PTR_ONE = AW'(1);
   localparam logic [14:0]    HIT_MAX = 15'h7FFF;

   typedef enum logic [1:0] {IDLE, COUNT, WRITE} state_t;

   state_t         state_q, state_d;
   logic [2:0]     gate_sync_q, gate_sync_d;
   logic [2:0]     hit_sync_q, hit_sync_d;
   logic [14:0]    hit_cnt_q, hit_cnt_d;
   logic           ovf_q, ovf_d;
   logic [11:0]    gate_num_q, gate_num_d;
   logic [AW-1:0]  wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]  rd_ptr_q, rd_ptr_d;
   logic [AW:0]    count_q, count_d;
   logic [7:0]     lost_q, lost_d;
   logic [31:0]    mem_q [FIFO_DEPTH];

   logic        gate_rise, gate_fall, hit_rise;
   logic        push, pop, full, empty, wr_en, drop;
   logic [31:0] word;

   // Both inputs share the same 2-flop + edge-register depth so their relative order survives.
   always_comb begin
      gate_sync_d = {gate_sync_q[1:0], GATE_IN};
      hit_sync_d  = {hit_sync_q[1:0], HIT_IN};
      gate_rise   = gate_sync_q[1] & ~gate_sync_q[2];
      gate_fall   = ~gate_sync_q[1] & gate_sync_q[2];
      hit_rise    = hit_sync_q[1] & ~hit_sync_q[2];
   end

   always_comb begin
      state_d   = state_q;
      hit_cnt_d = hit_cnt_q;
      ovf_d     = ovf_q;
      push      = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (gate_rise && ENABLE) begin
               state_d   = COUNT;
               hit_cnt_d = {14'd0, hit_rise};
               ovf_d     = 1'b0;
            end
         end
         COUNT: begin
            if (CLEAR) begin
               state_d = IDLE;
            end else begin
               if (hit_rise) begin
                  if (hit_cnt_q == HIT_MAX) ovf_d = 1'b1;
                  else                      hit_cnt_d = hit_cnt_q + 15'd1;
               end
               if (gate_fall) state_d = WRITE;
            end
         end
         WRITE: begin
            push = ~CLEAR;
            // A gate that re-rises during the write cycle opens the next window immediately.
            if (gate_rise && ENABLE) begin
               state_d   = COUNT;
               hit_cnt_d = {14'd0, hit_rise};
               ovf_d     = 1'b0;
            end else begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      word  = {DATA_IDENTIFIER, ovf_q, gate_num_q, hit_cnt_q};
      full  = (count_q == DEPTH_C);
      empty = (count_q == '0);
      pop   = FIFO_READ & ~empty & ~CLEAR;
      wr_en = push & (~full | pop);
      drop  = push & full & ~pop;

      gate_num_d = gate_num_q;
      wr_ptr_d   = wr_ptr_q;
      rd_ptr_d   = rd_ptr_q;
      count_d    = count_q;
      lost_d     = lost_q;
      if (CLEAR) begin
         gate_num_d = '0;
         wr_ptr_d   = '0;
         rd_ptr_d   = '0;
         count_d    = '0;
         lost_d     = '0;
      end else begin
         if (state_q == WRITE) gate_num_d = gate_num_q + 12'd1;
         if (wr_en) wr_ptr_d = wr_ptr_q + PTR_ONE;
         if (pop)   rd_ptr_d = rd_ptr_q + PTR_ONE;
         unique case ({wr_en, pop})
            2'b10:   count_d = count_q + CNT_ONE;
            2'b01:   count_d = count_q - CNT_ONE;
            default: count_d = count_q;
         endcase
         if (drop && lost_q != 8'hFF) lost_d = lost_q + 8'd1;
      end
   end

   always_ff @(posedge BUS_CLK or negedge BUS_RST_B) begin
      if (!BUS_RST_B) begin
         state_q     <= IDLE;
         gate_sync_q <= '0;
         hit_sync_q  <= '0;
         hit_cnt_q   <= '0;
         ovf_q       <= 1'b0;
         gate_num_q  <= '0;
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         count_q     <= '0;
         lost_q      <= '0;
      end else begin
         state_q     <= state_d;
         gate_sync_q <= gate_sync_d;
         hit_sync_q  <= hit_sync_d;
         hit_cnt_q   <= hit_cnt_d;
         ovf_q       <= ovf_d;
         gate_num_q  <= gate_num_d;
         wr_ptr_q    <= wr_ptr_d;
         rd_ptr_q    <= rd_ptr_d;
         count_q     <= count_d;
         lost_q      <= lost_d;
      end
   end

   // Storage needs no reset: the head word is masked to zero whenever the FIFO is empty.
   always_ff @(posedge BUS_CLK) begin
      if (wr_en) mem_q[wr_ptr_q] <= word;
   end

   assign FIFO_EMPTY = empty;
   assign FIFO_DATA  = empty ? 32'd0 : mem_q[rd_ptr_q];
   assign LOST_CNT   = lost_q;
   assign BUSY       = (state_q == COUNT);

endmodule

// File: tb/tb_ccpd_hit_gate_counter.sv
// Directed self-checking bench for ccpd_hit_gate_counter; inputs change and outputs are
// sampled on the falling clock edge, with hand-computed expected summary words.
module tb_ccpd_hit_gate_counter;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        enable = 1'b0;
   logic        gate = 1'b0;
   logic        hit = 1'b0;
   logic        clear = 1'b0;
   logic        rd = 1'b0;
   logic        empty;
   logic [31:0] data;
   logic [7:0]  lost;
   logic        busy;
   int          total = 0;
   int          bad = 0;

   always #10 clk = ~clk;

   ccpd_hit_gate_counter dut (
      .BUS_CLK    (clk),
      .BUS_RST_B  (rst_n),
      .ENABLE     (enable),
      .GATE_IN    (gate),
      .HIT_IN     (hit),
      .CLEAR      (clear),
      .FIFO_READ  (rd),
      .FIFO_EMPTY (empty),
      .FIFO_DATA  (data),
      .LOST_CNT   (lost),
      .BUSY       (busy)
   );

   task automatic tick(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic check_output(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
      total++;
      assert (observed === expected)
      else begin
         bad++;
         $error("[TB] FAIL %s: observed=0x%08h expected=0x%08h", tag, observed, expected);
      end
   endtask

   task automatic apply_stimulus(input logic g, input logic h, input int cycles);
      gate = g;
      hit  = h;
      tick(cycles);
   endtask

   task automatic run_window(input int hits);
      apply_stimulus(1'b1, 1'b0, 3);
      for (int i = 0; i < hits; i++) begin
         apply_stimulus(1'b1, 1'b1, 2);
         apply_stimulus(1'b1, 1'b0, 2);
      end
      apply_stimulus(1'b0, 1'b0, 8);
   endtask

   task automatic pop_word();
      rd = 1'b1;
      tick(1);
      rd = 1'b0;
   endtask

   task automatic pulse_clear();
      clear = 1'b1;
      tick(1);
      clear = 1'b0;
   endtask

   initial begin
      tick(3);
      check_output("rst_empty", {31'd0, empty}, 32'd1);
      check_output("rst_data", data, 32'd0);
      check_output("rst_lost", {24'd0, lost}, 32'd0);
      check_output("rst_busy", {31'd0, busy}, 32'd0);
      rst_n = 1'b1;
      enable = 1'b1;
      tick(2);

      // 100-cycle gate with seven 4-cycle hit pulses
      apply_stimulus(1'b1, 1'b0, 10);
      check_output("t1_busy_open", {31'd0, busy}, 32'd1);
      for (int i = 0; i < 7; i++) begin
         apply_stimulus(1'b1, 1'b1, 4);
         apply_stimulus(1'b1, 1'b0, 4);
      end
      apply_stimulus(1'b1, 1'b0, 34);
      apply_stimulus(1'b0, 1'b0, 8);
      check_output("t1_busy_closed", {31'd0, busy}, 32'd0);
      check_output("t1_empty", {31'd0, empty}, 32'd0);
      check_output("t1_word", data, 32'h7000_0007);
      pop_word();
      check_output("t1_empty_after_pop", {31'd0, empty}, 32'd1);

      // three windows of 5/0/9 hits
      pulse_clear();
      run_window(5);
      run_window(0);
      run_window(9);
      check_output("t2_word0", data, 32'h7000_0005);
      pop_word();
      check_output("t2_word1", data, 32'h7000_8000);
      pop_word();
      check_output("t2_word2", data, 32'h7001_0009);
      pop_word();
      check_output("t2_empty", {31'd0, empty}, 32'd1);

      // more than 0x7FFF hit edges in one gate saturates the count and sets OVF
      pulse_clear();
      apply_stimulus(1'b1, 1'b0, 3);
      for (int i = 0; i < 32800; i++) begin
         apply_stimulus(1'b1, 1'b1, 1);
         apply_stimulus(1'b1, 1'b0, 1);
      end
      apply_stimulus(1'b0, 1'b0, 8);
      check_output("t3_sat_word", data, 32'h7800_7FFF);
      pop_word();

      // 17 windows without reads: 16 kept, one dropped
      pulse_clear();
      for (int i = 0; i < 17; i++) run_window(0);
      check_output("t4_lost", {24'd0, lost}, 32'd1);
      check_output("t4_head", data, 32'h7000_0000);
      // pop coincides with the write cycle of an 18th window on the full FIFO
      apply_stimulus(1'b1, 1'b0, 4);
      apply_stimulus(1'b0, 1'b0, 1);
      tick(1);
      check_output("t4_busy_before_write", {31'd0, busy}, 32'd1);
      tick(1);
      check_output("t4_busy_in_write", {31'd0, busy}, 32'd0);
      pop_word();
      tick(4);
      check_output("t4_lost_after_pushpop", {24'd0, lost}, 32'd1);
      for (int i = 1; i < 16; i++) begin
         check_output("t4_drain", data, 32'h7000_0000 | (32'(i) << 15));
         pop_word();
      end
      check_output("t4_last", data, 32'h7008_8000);
      pop_word();
      check_output("t4_drained", {31'd0, empty}, 32'd1);

      // ENABLE=0 ignores a window; CLEAR inside a window writes nothing
      pulse_clear();
      enable = 1'b0;
      run_window(3);
      check_output("en0_empty", {31'd0, empty}, 32'd1);
      enable = 1'b1;
      apply_stimulus(1'b1, 1'b0, 3);
      apply_stimulus(1'b1, 1'b1, 2);
      apply_stimulus(1'b1, 1'b0, 2);
      check_output("clr_busy_before", {31'd0, busy}, 32'd1);
      pulse_clear();
      check_output("clr_busy_after", {31'd0, busy}, 32'd0);
      apply_stimulus(1'b0, 1'b0, 8);
      check_output("clr_empty", {31'd0, empty}, 32'd1);
      run_window(1);
      check_output("clr_next_word", data, 32'h7000_0001);
      pop_word();

      // reset in the middle of a window discards it
      pulse_clear();
      apply_stimulus(1'b1, 1'b0, 3);
      for (int i = 0; i < 3; i++) begin
         apply_stimulus(1'b1, 1'b1, 2);
         apply_stimulus(1'b1, 1'b0, 2);
      end
      rst_n = 1'b0;
      apply_stimulus(1'b0, 1'b0, 2);
      check_output("t5_rst_busy", {31'd0, busy}, 32'd0);
      check_output("t5_rst_empty", {31'd0, empty}, 32'd1);
      rst_n = 1'b1;
      tick(2);
      run_window(2);
      check_output("t5_word", data, 32'h7000_0002);
      pop_word();
      check_output("t5_only_word", {31'd0, empty}, 32'd1);

      // back-to-back windows: hit on the fall, gate re-rising in the write cycle, hit on the rise
      pulse_clear();
      apply_stimulus(1'b1, 1'b0, 3);
      for (int i = 0; i < 2; i++) begin
         apply_stimulus(1'b1, 1'b1, 2);
         apply_stimulus(1'b1, 1'b0, 2);
      end
      apply_stimulus(1'b0, 1'b1, 1);
      apply_stimulus(1'b1, 1'b1, 1);
      apply_stimulus(1'b1, 1'b0, 2);
      apply_stimulus(1'b1, 1'b1, 2);
      apply_stimulus(1'b1, 1'b0, 2);
      apply_stimulus(1'b0, 1'b0, 1);
      apply_stimulus(1'b1, 1'b1, 1);
      apply_stimulus(1'b1, 1'b0, 3);
      apply_stimulus(1'b0, 1'b0, 8);
      check_output("t6_word_a", data, 32'h7000_0003);
      pop_word();
      check_output("t6_word_b", data, 32'h7000_8001);
      pop_word();
      check_output("t6_word_c", data, 32'h7001_0001);
      pop_word();
      check_output("t6_empty", {31'd0, empty}, 32'd1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
